// File: rtl/minmax_share_ctrl_if.sv
// Requester, finder and result signals of the shared min/max controller.
// master = controller side, slave = requesters/finder/consumer side.
interface minmax_share_ctrl_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 3,
  parameter int unsigned IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] x_bus;
  logic [N_REQ*W-1:0] y_bus;
  logic [N_REQ*W-1:0] z_bus;
  logic [N_REQ-1:0]   gnt;
  logic               f_start;
  logic [W-1:0]       f_xin;
  logic [W-1:0]       f_yin;
  logic [W-1:0]       f_zin;
  logic               f_ack;
  logic               f_done;
  logic [W-1:0]       f_max;
  logic [W-1:0]       f_min;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic [W-1:0]       res_max;
  logic [W-1:0]       res_min;
  logic               busy;

  modport master (
    input  req, x_bus, y_bus, z_bus, f_done, f_max, f_min, res_ready,
    output gnt, f_start, f_xin, f_yin, f_zin, f_ack,
           res_valid, res_id, res_max, res_min, busy
  );

  modport slave (
    output req, x_bus, y_bus, z_bus, f_done, f_max, f_min, res_ready,
    input  gnt, f_start, f_xin, f_yin, f_zin, f_ack,
           res_valid, res_id, res_max, res_min, busy
  );
endinterface

// File: rtl/minmax_share_ctrl.sv
// Round-robin arbiter sharing one min/max finder between N_REQ requesters,
// returning tagged results through a valid/ready output register.
module minmax_share_ctrl #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 3,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input logic                clk,
  input logic                reset,
  minmax_share_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur_id;
  logic [W-1:0]     op_x, op_y, op_z;
  logic [N_REQ-1:0] gnt_q;
  logic             start_q, ack_q, busy_q;
  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [W-1:0]     res_max_q, res_min_q;

  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic [W-1:0]     win_x, win_y, win_z;
  logic             slot_free;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int unsigned idx;
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!win_found && bus.req[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign win_x     = W'(bus.x_bus >> (32'(win_id) * W));
  assign win_y     = W'(bus.y_bus >> (32'(win_id) * W));
  assign win_z     = W'(bus.z_bus >> (32'(win_id) * W));
  assign slot_free = !res_valid_q || bus.res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDW'(N_REQ - 1);
      cur_id      <= '0;
      op_x        <= '0;
      op_y        <= '0;
      op_z        <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_max_q   <= '0;
      res_min_q   <= '0;
    end else begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      // Consumer drain; a capture further down on the same edge overrides it.
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            op_x    <= win_x;
            op_y    <= win_y;
            op_z    <= win_z;
            cur_id  <= win_id;
            ptr     <= win_id;
            gnt_q   <= N_REQ'(1) << win_id;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Finder keeps Done high, so stalling here loses nothing.
          if (bus.f_done && slot_free) begin
            res_valid_q <= 1'b1;
            res_id_q    <= cur_id;
            res_max_q   <= bus.f_max;
            res_min_q   <= bus.f_min;
            ack_q       <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.f_start   = start_q;
  assign bus.f_ack     = ack_q;
  assign bus.f_xin     = op_x;
  assign bus.f_yin     = op_y;
  assign bus.f_zin     = op_z;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_min   = res_min_q;

endmodule

// File: tb/tb_minmax_share_ctrl.sv
// Bench for minmax_share_ctrl: behavioural finder, round-robin/scoreboard
// reference, directed scenarios followed by randomized traffic.
module tb_minmax_share_ctrl;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned W     = 3;
  localparam int unsigned IDW   = 2;

  typedef struct { int id; int mx; int mn; } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  minmax_share_ctrl_if #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) bus();

  minmax_share_ctrl #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int ref_ptr;
  int last_gnt;
  int ox[N_REQ];
  int oy[N_REQ];
  int oz[N_REQ];
  logic [N_REQ-1:0] req_v;
  exp_t q[$];

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Finder latency in cycles after start: 1 = best case, 6 = worst (all equal).
  function automatic int lat_of(int a, int b, int c);
    if (a == b && b == c) return 6;
    if (a > b && b > c) return 1;
    return 2 + (a + b + c) % 4;
  endfunction

  function automatic int rr_winner(logic [N_REQ-1:0] rq, int p);
    for (int k = 1; k <= int'(N_REQ); k++) begin
      int i = (p + k) % int'(N_REQ);
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  // Behavioural finder: holds Done until acknowledged.
  logic fbusy;
  int   fcnt, flat;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.f_done <= 1'b0;
      bus.f_max  <= '0;
      bus.f_min  <= '0;
      fbusy      <= 1'b0;
      fcnt       <= 0;
      flat       <= 1;
    end else if (bus.f_ack) begin
      bus.f_done <= 1'b0;
      fbusy      <= 1'b0;
    end else if (!fbusy && bus.f_start) begin
      fbusy     <= 1'b1;
      fcnt      <= 1;
      flat      <= lat_of(int'(bus.f_xin), int'(bus.f_yin), int'(bus.f_zin));
      bus.f_max <= W'(max3(int'(bus.f_xin), int'(bus.f_yin), int'(bus.f_zin)));
      bus.f_min <= W'(min3(int'(bus.f_xin), int'(bus.f_yin), int'(bus.f_zin)));
    end else if (fbusy && !bus.f_done) begin
      if (fcnt >= flat) bus.f_done <= 1'b1;
      else fcnt <= fcnt + 1;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [N_REQ*W-1:0] xb, yb, zb;
    for (int i = 0; i < int'(N_REQ); i++) begin
      xb[i*W +: W] = W'(ox[i]);
      yb[i*W +: W] = W'(oy[i]);
      zb[i*W +: W] = W'(oz[i]);
    end
    bus.req   = req_v;
    bus.x_bus = xb;
    bus.y_bus = yb;
    bus.z_bus = zb;
  endtask

  // One clock: protocol checks, grant prediction, scoreboard on accepted results.
  task automatic step();
    logic acc, hold;
    logic [N_REQ-1:0] rq;
    int sid, smx, smn, w;
    exp_t e;
    rq   = req_v;
    acc  = bus.res_valid && bus.res_ready;
    hold = bus.res_valid && !bus.res_ready;
    sid  = int'(bus.res_id);
    smx  = int'(bus.res_max);
    smn  = int'(bus.res_min);
    last_gnt = -1;
    @(posedge clk); #1;
    if (acc) begin
      if (q.size() == 0) chk("result_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_id", sid, e.id);
        chk("res_max", smx, e.mx);
        chk("res_min", smn, e.mn);
      end
    end
    if (hold) begin
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_id", bus.res_id, sid);
      chk("hold_max", bus.res_max, smx);
      chk("hold_min", bus.res_min, smn);
    end
    chk("start_ack_overlap", bus.f_start & bus.f_ack, 0);
    if (bus.gnt !== '0) begin
      w = rr_winner(rq, ref_ptr);
      chk("gnt_start", bus.f_start, 1);
      if (w < 0) chk("gnt_no_req", bus.gnt, 0);
      else begin
        chk("gnt", bus.gnt, 32'(1) << w);
        q.push_back('{w, max3(ox[w], oy[w], oz[w]), min3(ox[w], oy[w], oz[w])});
        ref_ptr  = w;
        last_gnt = w;
      end
    end else begin
      chk("start_without_gnt", bus.f_start, 0);
    end
  endtask

  task automatic wait_gnt(int budget, output int w);
    int n = 0;
    w = -1;
    while (w < 0 && n < budget) begin
      step();
      w = last_gnt;
      n++;
    end
    if (w < 0) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_valid(int budget, output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.res_valid !== 1'b1) chk("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_v = '0;
    drive();
    bus.res_ready = 1'b1;
    while ((q.size() != 0 || bus.busy || bus.res_valid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_busy", bus.busy, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_f_start"}, bus.f_start, 0);
    chk({tag, "_f_ack"}, bus.f_ack, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_id"}, bus.res_id, 0);
    chk({tag, "_res_max"}, bus.res_max, 0);
    chk({tag, "_res_min"}, bus.res_min, 0);
    chk({tag, "_ops"}, {bus.f_xin, bus.f_yin, bus.f_zin}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    ref_ptr = int'(N_REQ) - 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < int'(N_REQ); i++) begin ox[i] = 0; oy[i] = 0; oz[i] = 0; end
    req_v = '0;
    drive();
    bus.res_ready = 1'b1;
    do_reset();
    check_zero("reset");

    // Single request, best-case latency.
    ox[0] = 5; oy[0] = 3; oz[0] = 1;
    req_v = 4'b0001;
    drive();
    step();
    chk("single_gnt", bus.gnt, 4'b0001);
    chk("single_busy", bus.busy, 1);
    chk("single_ops", {bus.f_xin, bus.f_yin, bus.f_zin}, {3'd5, 3'd3, 3'd1});
    req_v = '0;
    drive();
    wait_valid(20, n);
    chk("single_latency", n, 3);
    chk("single_id", bus.res_id, 0);
    chk("single_max", bus.res_max, 5);
    chk("single_min", bus.res_min, 1);
    chk("single_ack", bus.f_ack, 1);
    step();
    chk("single_ack_pulse", bus.f_ack, 0);
    chk("single_idle", bus.busy, 0);

    // Worst-case path on requester 2.
    ox[2] = 4; oy[2] = 4; oz[2] = 4;
    req_v = 4'b0100;
    drive();
    wait_gnt(10, w);
    chk("worst_gnt", w, 2);
    req_v = '0;
    drive();
    wait_valid(20, n);
    chk("worst_latency", n, 8);
    chk("worst_id", bus.res_id, 2);
    chk("worst_max", bus.res_max, 4);
    chk("worst_min", bus.res_min, 4);
    drain();

    // Fairness from reset pointer with all requesters active.
    do_reset();
    check_zero("reset2");
    for (int i = 0; i < int'(N_REQ); i++) begin
      ox[i] = i + 1; oy[i] = (i + 3) % 8; oz[i] = 7 - i;
    end
    req_v = 4'b1111;
    drive();
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      step();
      if (last_gnt >= 0) begin
        chk("fair_order", last_gnt, exp_order[n]);
        n++;
        if (n == 5) begin req_v = '0; drive(); end
      end
    end
    chk("fair_count", n, 5);
    drain();

    // Backpressure: second result stalls in WAIT until the consumer is ready.
    bus.res_ready = 1'b0;
    ox[0] = 6; oy[0] = 2; oz[0] = 0;
    req_v = 4'b0001;
    drive();
    wait_gnt(10, w);
    req_v = '0;
    drive();
    wait_valid(20, n);
    ox[1] = 1; oy[1] = 7; oz[1] = 2;
    req_v = 4'b0010;
    drive();
    wait_gnt(10, w);
    chk("bp_gnt", w, 1);
    req_v = '0;
    drive();
    for (int c = 0; c < 12; c++) begin
      step();
      chk("bp_no_ack", bus.f_ack, 0);
    end
    chk("bp_busy", bus.busy, 1);
    chk("bp_done_held", bus.f_done, 1);
    chk("bp_old_id", bus.res_id, 0);
    chk("bp_old_max", bus.res_max, 6);
    chk("bp_old_min", bus.res_min, 0);
    bus.res_ready = 1'b1;
    step();
    chk("handoff_valid", bus.res_valid, 1);
    chk("handoff_id", bus.res_id, 1);
    chk("handoff_max", bus.res_max, 7);
    chk("handoff_min", bus.res_min, 1);
    chk("handoff_ack", bus.f_ack, 1);
    step();
    chk("handoff_drained", bus.res_valid, 0);
    drain();

    // Reset while the finder is working.
    ox[0] = 3; oy[0] = 5; oz[0] = 1;
    req_v = 4'b0001;
    drive();
    wait_gnt(10, w);
    req_v = '0;
    drive();
    step();
    step();
    chk("mid_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_zero("mid_reset_async");
    q.delete();
    ref_ptr = int'(N_REQ) - 1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("mid_reset");
    ox[0] = 2; oy[0] = 6; oz[0] = 4;
    ox[1] = 2; oy[1] = 6; oz[1] = 4;
    req_v = 4'b0011;
    drive();
    wait_gnt(10, w);
    chk("post_reset_ptr", w, 0);
    req_v = 4'b0010;
    drive();
    wait_gnt(20, w);
    chk("post_reset_second", w, 1);
    drain();

    // Randomized traffic and consumer backpressure.
    for (int c = 0; c < 400; c++) begin
      if (last_gnt >= 0 && $urandom_range(1, 0) == 0) req_v[last_gnt] = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!req_v[i] && i != last_gnt && $urandom_range(3, 0) == 0) begin
          ox[i] = int'($urandom_range(7, 0));
          oy[i] = int'($urandom_range(7, 0));
          oz[i] = int'($urandom_range(7, 0));
          req_v[i] = 1'b1;
        end
      end
      bus.res_ready = ($urandom_range(9, 0) < 7);
      drive();
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
